// File: rtl/uart_echo_ctrl.sv
// UART echo controller: receiver bytes are buffered in a DEPTH-entry FIFO and replayed to the transmitter in order.
// Latency: a byte captured at edge N is loaded into the transmitter at edge N+1 at the earliest (wr_tx high the cycle after).
// Backpressure: tbr=0 or enable=0 stalls TX loads; a full FIFO drops the received byte and sets the sticky ovf flag.

// Generic single-clock FIFO with registered occupancy; push when full and pop when empty are ignored.
// Latency: a pushed entry becomes visible at head_dat one cycle after the push edge.
// Backpressure: the caller must check count; the FIFO never overwrites or underflows.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_vld,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Guard against overflow/underflow using the occupancy seen before the edge.
    always_comb begin
        push_ok = push_vld && (count != FULL_CNT);
        pop_ok  = pop_vld && (count != '0);
    end

    assign head_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_echo_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       rda,
    input  logic [7:0]                 rx_data,
    output logic                       rd_rx,
    input  logic                       tbr,
    output logic                       wr_tx,
    output logic [7:0]                 wr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    input  logic                       ovf_clr
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_HOLD} tx_state_t;

    rx_state_t  rx_state, rx_state_nxt;
    tx_state_t  tx_state, tx_state_nxt;
    logic       hold_cnt;
    logic       rx_start;
    logic       tx_start;
    logic       fifo_full;
    logic       discard;
    logic [7:0] head_dat;

    // The full check uses pre-edge occupancy, so a simultaneous pop does not make room for the new byte.
    fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rx_start && !fifo_full),
        .push_dat (rx_data),
        .pop_vld  (tx_start),
        .head_dat (head_dat),
        .count    (count)
    );

    assign fifo_full = (count == FULL_CNT);
    assign discard   = rx_start && fifo_full;
    assign rd_rx     = (rx_state == R_ACK);
    assign wr_tx     = (tx_state == T_LOAD);

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    // RX next state: only R_IDLE looks at rda/enable; the ack/wait tail always completes.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_start     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rda && enable) begin
                    rx_start     = 1'b1;
                    rx_state_nxt = R_ACK;
                end
            end
            R_ACK:   rx_state_nxt = R_WAIT;
            R_WAIT:  rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // TX state register plus the two-cycle hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            hold_cnt <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            hold_cnt <= (tx_state == T_HOLD) && !hold_cnt;
        end
    end

    // TX next state: a load needs data, a ready transmitter and enable; load and hold always run to the end.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_start     = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if ((count != '0) && tbr && enable) begin
                    tx_start     = 1'b1;
                    tx_state_nxt = T_LOAD;
                end
            end
            T_LOAD:  tx_state_nxt = T_HOLD;
            T_HOLD:  tx_state_nxt = hold_cnt ? T_IDLE : T_HOLD;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // Transmit data register holds the last popped byte; sticky overflow where a discard beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data <= 8'h00;
            ovf     <= 1'b0;
        end else begin
            if (tx_start) begin
                wr_data <= head_dat;
            end
            if (discard) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_echo_ctrl.md
UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEPTH, 8, number of FIFO entries (power of two, minimum 2).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  1 = accept new RX bytes and issue new TX loads; 0 = start neither.
REQ-006 rda  input  1  receiver has a byte available.
REQ-007 rx_data  input  8  receiver byte, valid while rda=1.
REQ-008 rd_rx  output  1  one-cycle pulse that consumes the receiver byte.
REQ-009 tbr  input  1  transmitter buffer ready; 1 = wr_tx is accepted.
REQ-010 wr_tx  output  1  one-cycle pulse that loads wr_data into the transmitter.
REQ-011 wr_data  output  8  byte presented to the transmitter.
REQ-012 count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 ovf  output  1  sticky flag: at least one byte was dropped because the FIFO was full.
REQ-014 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-015 The block SHALL buffer bytes read from the receiver in a DEPTH-entry FIFO and forward them to the transmitter in arrival order.
REQ-016 RX FSM states SHALL be R_IDLE, R_ACK and R_WAIT.
REQ-017 In R_IDLE with rda=1 and enable=1, the FSM SHALL go to R_ACK at the next edge, drive rd_rx=1 for exactly that cycle, and capture rx_data at that same edge.
REQ-018 The captured byte SHALL be pushed at the R_IDLE->R_ACK edge if count<DEPTH; otherwise it SHALL be discarded and ovf set.
REQ-019 The RX FSM SHALL go R_ACK->R_WAIT->R_IDLE unconditionally, one cycle each, and SHALL ignore rda outside R_IDLE.
REQ-020 TX FSM states SHALL be T_IDLE, T_LOAD and T_HOLD.
REQ-021 In T_IDLE with count>0, tbr=1 and enable=1, the FSM SHALL go to T_LOAD at the next edge, registering wr_tx=1, loading wr_data with the FIFO head, and popping it at that same edge.
REQ-022 The TX FSM SHALL go T_LOAD->T_HOLD (2 cycles)->T_IDLE unconditionally and SHALL ignore tbr outside T_IDLE.
REQ-023 wr_data SHALL hold the last loaded byte until the next load.
REQ-024 A push and a pop on the same edge SHALL both occur, leaving count unchanged, and the popped byte SHALL be the older head.
REQ-025 A byte SHALL NOT be popped on the same edge it is pushed into an empty FIFO; minimum RX-capture-to-wr_tx latency is 2 cycles.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or underflow below 0.
REQ-027 ovf SHALL set on a discard and clear on ovf_clr=1; if both occur on the same edge, set SHALL win.
REQ-028 Deasserting enable SHALL NOT abort an RX or TX sequence already past its IDLE state.

Reset
REQ-029 While rst_n=0, outputs SHALL be: rd_rx=0, wr_tx=0, wr_data=8'h00, count=0, ovf=0.
REQ-030 While rst_n=0, both FSMs SHALL be in their IDLE states and both pointers SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all buffered bytes, and no pre-reset byte SHALL be transmitted after release.
REQ-032 The first action after rst_n rises SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 Reset: apply rst_n=0 with rda=1 and tbr=1 -> rd_rx=0, wr_tx=0, wr_data=00, count=0, ovf=0 throughout.
REQ-034 Single byte: enable=1, tbr=1, rda=1 with rx_data=A5 -> rd_rx is high for exactly 1 cycle; then 2 cycles after the capture edge, wr_tx is high for 1 cycle with wr_data=A5; count returns to 0.
REQ-035 Full/overflow: tbr=0, feed bytes 01..08 -> count=8 with no wr_tx; feed 09 -> rd_rx still pulses, ovf=1, count=8; raise tbr -> bytes 01..08 are sent in order and 09 is never sent.
REQ-036 Simultaneous push/pop: with count=3, align an RX capture with a TX load -> count stays 3 and output order is preserved.
REQ-037 enable=0 with rda=1 and count=2 -> no rd_rx and no wr_tx; raise enable -> both resume; ovf_clr pulsed on the same edge as a discard -> ovf=1.
REQ-038 Mid-operation reset: with count=3, pulse rst_n low -> count=0; after release with tbr=1, no wr_tx occurs until a new byte arrives.
